// File: rtl/gcn_transform_scheduler_if.sv
// Handshake and memory-port bundle between the GCN
// transform scheduler and its environment.
interface gcn_transform_scheduler_if #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int ROW_WIDTH     = 3,
  parameter int COL_WIDTH     = 2
);
  logic                     start;
  logic                     calc_done;
  logic                     enable_read;
  logic [ADDRESS_WIDTH-1:0] read_address;
  logic                     weight_load;
  logic                     feature_load;
  logic                     calc_en;
  logic                     result_write;
  logic [ROW_WIDTH-1:0]     write_row;
  logic [COL_WIDTH-1:0]     write_col;
  logic                     done;
  logic                     error;

  modport master (
    output start,
    output calc_done,
    input  enable_read,
    input  read_address,
    input  weight_load,
    input  feature_load,
    input  calc_en,
    input  result_write,
    input  write_row,
    input  write_col,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  calc_done,
    output enable_read,
    output read_address,
    output weight_load,
    output feature_load,
    output calc_en,
    output result_write,
    output write_row,
    output write_col,
    output done,
    output error
  );
endinterface

// File: rtl/gcn_transform_scheduler.sv
// Sequencer for the FM x WM transform stage: loads operands,
// hands off dot products and writes results into FM_WM.
module gcn_transform_scheduler #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int ADDRESS_WIDTH         = 13,
  parameter int FEATURE_BASE          = 512,
  parameter int CALC_TIMEOUT          = 255,
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
  input logic clk,
  input logic reset,
  gcn_transform_scheduler_if.slave bus
);

  localparam int TW = $clog2(CALC_TIMEOUT + 1);
  localparam int AW = ADDRESS_WIDTH;
  localparam int WW = COUNTER_WEIGHT_WIDTH;
  localparam int FW = COUNTER_FEATURE_WIDTH;

  localparam logic [TW-1:0] TMO_LAST = TW'(CALC_TIMEOUT - 1);
  localparam logic [FW-1:0] F_LAST   = FW'(FEATURE_ROWS - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(WEIGHT_COLS - 1);
  localparam logic [AW-1:0] F_BASE   = AW'(FEATURE_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_F,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_w_idx;
  logic [WW-1:0] w_w_nxt;
  logic [FW-1:0] r_f_idx;
  logic [FW-1:0] w_f_nxt;
  logic [TW-1:0] r_tmo;
  logic [TW-1:0] w_tmo_nxt;
  logic          r_error;
  logic          w_err_nxt;

  // state, index, timeout and error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_w_idx <= '0;
      r_f_idx <= '0;
      r_tmo   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_w_idx <= w_w_nxt;
      r_f_idx <= w_f_nxt;
      r_tmo   <= w_tmo_nxt;
      r_error <= w_err_nxt;
    end
  end

  // next-state and counter update logic
  always_comb begin
    w_next    = r_state;
    w_w_nxt   = r_w_idx;
    w_f_nxt   = r_f_idx;
    w_tmo_nxt = r_tmo;
    w_err_nxt = r_error;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD_W;
      end
      S_LOAD_W: begin
        w_next = S_LOAD_F;
      end
      S_LOAD_F: begin
        w_next    = S_CALC;
        w_tmo_nxt = '0;
      end
      S_CALC: begin
        if (bus.calc_done) begin
          w_next = S_WRITE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
          if (r_tmo == TMO_LAST) begin
            w_err_nxt = 1'b1;
            w_next    = S_DONE;
          end
        end
      end
      S_WRITE: begin
        if (r_f_idx != F_LAST) begin
          w_f_nxt = r_f_idx + 1'b1;
          w_next  = S_LOAD_F;
        end else if (r_w_idx != W_LAST) begin
          w_f_nxt = '0;
          w_w_nxt = r_w_idx + 1'b1;
          w_next  = S_LOAD_W;
        end else begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.start) begin
          w_next    = S_IDLE;
          w_err_nxt = 1'b0;
          w_w_nxt   = '0;
          w_f_nxt   = '0;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Moore output decode from state, indices and error flag
  always_comb begin
    bus.enable_read  = 1'b0;
    bus.read_address = '0;
    bus.weight_load  = 1'b0;
    bus.feature_load = 1'b0;
    bus.calc_en      = 1'b0;
    bus.result_write = 1'b0;
    bus.write_row    = '0;
    bus.write_col    = '0;
    bus.done         = 1'b0;
    bus.error        = r_error;
    unique case (r_state)
      S_LOAD_W: begin
        bus.enable_read  = 1'b1;
        bus.read_address = AW'(r_w_idx);
        bus.weight_load  = 1'b1;
      end
      S_LOAD_F: begin
        bus.enable_read  = 1'b1;
        bus.read_address = F_BASE + AW'(r_f_idx);
        bus.feature_load = 1'b1;
      end
      S_CALC: begin
        bus.calc_en = 1'b1;
      end
      S_WRITE: begin
        bus.result_write = 1'b1;
        bus.write_row    = r_f_idx;
        bus.write_col    = r_w_idx;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gcn_transform_scheduler.sv
// Directed bench for gcn_transform_scheduler with a
// programmable dot-product stub and trace logging.
module tb_gcn_transform_scheduler;

  logic clk = 1'b0;
  logic reset;

  gcn_transform_scheduler_if #(
    .ADDRESS_WIDTH(13),
    .ROW_WIDTH(3),
    .COL_WIDTH(2)
  ) bus ();

  gcn_transform_scheduler #(
    .FEATURE_ROWS(6),
    .WEIGHT_COLS(3),
    .ADDRESS_WIDTH(13),
    .FEATURE_BASE(512),
    .CALC_TIMEOUT(255)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int k    = 3;
  int hang = -1;
  bit hi   = 1'b0;
  int ccnt = 0;
  int ncalc, nbad, cyc, c0, c1;
  logic [14:0] aq[$];
  logic [4:0]  wq[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.enable_read, bus.read_address,
                bus.weight_load, bus.feature_load,
                bus.calc_en, bus.result_write,
                bus.write_row, bus.write_col,
                bus.done, bus.error});
  endfunction

  task automatic clr();
    aq.delete();
    wq.delete();
    ncalc = 0;
    nbad  = 0;
    c0    = -1;
    c1    = -1;
  endtask

  // monitor plus dot-product stub; calc_done rises in the
  // k-th CALC cycle except on product index "hang"
  initial begin
    cyc = 0;
    clr();
    bus.calc_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.enable_read)
        aq.push_back({bus.weight_load, bus.feature_load,
                      bus.read_address});
      if (bus.enable_read !=
          (bus.weight_load ^ bus.feature_load))
        nbad++;
      if (!bus.enable_read && bus.read_address != 0)
        nbad++;
      if (bus.weight_load && c0 < 0) c0 = cyc;
      if (bus.result_write)
        wq.push_back({bus.write_row, bus.write_col});
      if (bus.calc_en) ncalc++;
      if (bus.done && c1 < 0) c1 = cyc;
      ccnt = bus.calc_en ? ccnt + 1 : 0;
      bus.calc_done = hi ||
        (bus.calc_en && ccnt == k && wq.size() != hang);
    end
  end

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && c1 < 0; i++) @(negedge clk);
    chk("done_seen", 32'(c1 >= 0), 1);
  endtask

  task automatic chk_seq();
    logic [14:0] ea[$];
    chk("n_wr", wq.size(), 18);
    for (int w = 0; w < 3; w++)
      for (int f = 0; f < 6; f++)
        if (w * 6 + f < wq.size())
          chk("wr_rc", 32'(wq[w*6+f]), 32'(f * 4 + w));
    for (int w = 0; w < 3; w++) begin
      ea.push_back({2'b10, 13'(w)});
      for (int f = 0; f < 6; f++)
        ea.push_back({2'b01, 13'(512 + f)});
    end
    chk("n_rd", aq.size(), 21);
    for (int i = 0; i < 21; i++)
      if (i < aq.size())
        chk("rd_addr", 32'(aq[i]), 32'(ea[i]));
    chk("rd_bad", nbad, 0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", outs(), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 0);

    // nominal pass, k=3, start held
    clr();
    bus.start = 1'b1;
    wait_done(200);
    chk("nom_lat", 32'(c1 - c0), 93);
    chk("nom_err", 32'(bus.error), 0);
    chk_seq();
    repeat (10) @(negedge clk);
    chk("hold_done", 32'(bus.done), 1);
    chk("hold_nrd", aq.size(), 21);
    bus.start = 1'b0;
    @(negedge clk);
    chk("back_idle", outs(), 0);

    // minimal latency, calc_done stuck high, 1-cycle start
    hi = 1'b1;
    clr();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(100);
    chk("min_lat", 32'(c1 - c0), 57);
    chk("min_ncalc", ncalc, 18);
    chk_seq();
    hi = 1'b0;
    repeat (2) @(negedge clk);
    chk("min_idle", outs(), 0);

    // timeout on product 1 (row 1, col 0)
    clr();
    hang = 1;
    bus.start = 1'b1;
    wait_done(400);
    chk("tmo_lat", 32'(c1 - c0), 262);
    chk("tmo_err", 32'(bus.error), 1);
    chk("tmo_done", 32'(bus.done), 1);
    chk("tmo_nwr", wq.size(), 1);
    bus.start = 1'b0;
    hang = -1;
    @(negedge clk);
    chk("tmo_clr_err", 32'(bus.error), 0);
    chk("tmo_clr_done", 32'(bus.done), 0);

    // reset during CALC of row 3 col 1
    clr();
    bus.start = 1'b1;
    for (int i = 0; i < 200 && wq.size() < 9; i++)
      @(negedge clk);
    for (int i = 0; i < 20 && !bus.calc_en; i++)
      @(negedge clk);
    chk("rst_in_calc", 32'(bus.calc_en), 1);
    chk("rst_nwr_pre", wq.size(), 9);
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_outs", outs(), 0);
    repeat (5) @(negedge clk);
    chk("rst_nwr_post", wq.size(), 9);

    // restart by pulse, toggle start during CALC
    clr();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.calc_en; i++)
      @(negedge clk);
    bus.start = 1'b1;
    repeat (4) @(negedge clk);
    bus.start = 1'b0;
    wait_done(200);
    chk("re_lat", 32'(c1 - c0), 93);
    chk("re_err", 32'(bus.error), 0);
    chk_seq();
    repeat (2) @(negedge clk);
    chk("re_idle", outs(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/gcn_transform_scheduler.md
Name: gcn_transform_scheduler

Overview:
- Sequences the feature-by-weight transformation stage (FM × WM) of the GCN accelerator.
- Issues weight-column and feature-row read addresses to the shared input memory port, and loads the dot-product unit's operand buffers.
- Hands off each dot product with a calc_en/calc_done handshake, then writes each result into the FM_WM output buffer at (row, col).
- Sits between the top-level start/done interface and the dot-product datapath; the downstream COO aggregation stage begins once done asserts.

Parameters:
- FEATURE_ROWS, 6, number of nodes (feature matrix rows)
- WEIGHT_COLS, 3, number of weight columns (output classes)
- ADDRESS_WIDTH, 13, input memory address width
- FEATURE_BASE, 512, address of feature row 0; weight column w is at address w
- CALC_TIMEOUT, 255, maximum cycles to wait in CALC for calc_done
- COUNTER_WEIGHT_WIDTH, $clog2(WEIGHT_COLS), width of the weight column index
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), width of the feature row index

Ports:
- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  level; begins a pass when sampled high in IDLE
- calc_done  in  1  dot-product result valid, from the datapath
- enable_read  out  1  input memory read enable
- read_address  out  ADDRESS_WIDTH  input memory address
- weight_load  out  1  capture data_in into the weight operand buffer
- feature_load  out  1  capture data_in into the feature operand buffer
- calc_en  out  1  held high while a dot product is requested
- result_write  out  1  write the dot-product result into FM_WM
- write_row  out  COUNTER_FEATURE_WIDTH  FM_WM row index
- write_col  out  COUNTER_WEIGHT_WIDTH  FM_WM column index
- done  out  1  pass complete
- error  out  1  pass aborted on a calc_done timeout

Behaviour:
- Output style: Moore. Every output is decoded from registered state, the counters w_idx/f_idx, and the error flag.
- Memory port: read data is combinational. data_in is valid in the same cycle as read_address while enable_read=1.
- Reset: state=IDLE; w_idx=0, f_idx=0, timeout counter=0, error=0. All outputs are 0, including read_address=0.
- Reset mid-operation: reset takes priority in any state. It aborts the pass with no further result_write.
- IDLE: all strobes are 0. If start=1, go to LOAD_W.
- LOAD_W (1 cycle): enable_read=1, read_address=w_idx, weight_load=1. Next state is LOAD_F.
- LOAD_F (1 cycle): enable_read=1, read_address=FEATURE_BASE+f_idx, feature_load=1. Next state is CALC.
- CALC (on entry the timeout counter clears to 0):
  - calc_en=1 every cycle in CALC.
  - If calc_done=1 this cycle, go to WRITE. CALC therefore lasts at least 1 cycle.
  - Otherwise the counter increments. When the counter reaches CALC_TIMEOUT, set error=1 and go to DONE.
  - calc_done seen outside CALC is ignored.
- WRITE (1 cycle): result_write=1, write_row=f_idx, write_col=w_idx. Then:
  - If f_idx<FEATURE_ROWS-1: f_idx++, go to LOAD_F.
  - Else if w_idx<WEIGHT_COLS-1: f_idx=0, w_idx++, go to LOAD_W.
  - Else go to DONE.
- write_row/write_col drive 0 outside WRITE. read_address drives 0 whenever enable_read=0.
- DONE:
  - done=1; error holds its value.
  - Stay in DONE while start=1. When start=0, return to IDLE and clear error, w_idx and f_idx.
  - A start held high after done does not begin a second pass. start must drop first.
- start changes during LOAD_W..WRITE are ignored.
- Ordering: weight column major, feature row minor. Each weight column is loaded once per column. Each feature row is reloaded once per weight column.
- Cycle count with a fixed CALC of k cycles: WEIGHT_COLS×(1+FEATURE_ROWS×(k+2)) cycles from LOAD_W entry to DONE entry.

Test Plan:
- Nominal pass: MAC stub asserts calc_done in the 3rd CALC cycle (k=3), start held high.
  - 18 result_write pulses with (row,col) = (0,0),(1,0)…(5,0),(0,1)…(5,2).
  - done rises exactly 93 cycles after the cycle in which start is sampled; error=0.
- Address trace, same run:
  - enable_read is high only in LOAD_W/LOAD_F.
  - Addresses are 0,512,513…517,1,512…517,2,512…517.
  - weight_load and feature_load pulses match these addresses one-for-one.
- Minimal latency: calc_done held constantly high (k=1).
  - Total of 3×(1+6×3)=57 cycles to done.
  - calc_en is high exactly 18 cycles in total.
- Timeout: calc_done never asserted on the 2nd product, row 1 col 0.
  - error=1 and done=1 after CALC_TIMEOUT cycles in CALC.
  - Only 1 result_write has been issued.
  - Deasserting start returns the block to IDLE with error=0.
- Reset mid-pass: assert reset for 1 cycle during CALC of row 3 col 1.
  - All outputs are 0 on the following cycle.
  - Restarting produces a full clean pass from (0,0).
- Start handling:
  - start held high through DONE gives no second pass; done stays 1.
  - start toggled during CALC has no effect.
  - start pulsed in IDLE for 1 cycle launches a pass.
